// File: rtl/tetris_pkg.sv
// tetris_pkg: shared types, shape offset table, colour/LFSR helpers for the active-piece controller.
// PIECE_MOVER_ROTATE_EN selects the four-rotation shape table; otherwise only rotation 0 exists.
package tetris_pkg;
   typedef enum logic [2:0] {SPAWN, IDLE, REQ, RELEASE, OVER} state_t;
   typedef logic signed [2:0] off_t;
   typedef struct packed {
      off_t dv;
      off_t dh;
   } off_pair_t;
   localparam off_t M1 = -3'sd1;
   localparam off_t Z0 = 3'sd0;
   localparam off_t P1 = 3'sd1;
   localparam off_t P2 = 3'sd2;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;
   localparam logic [4:0] WALL_L = 5'd0;
   localparam logic [4:0] WALL_R = 5'd11;
   localparam logic [4:0] FLOOR_H = 5'd20;
   // Piece types I, O, T, S, Z, J, L; each entry is (column, row) offset from the anchor.
`ifdef PIECE_MOVER_ROTATE_EN
   localparam int N_ROT = 4;
   localparam off_pair_t SHAPE_TBL [0:6][0:N_ROT-1][0:3] = '{
      '{'{'{M1,Z0},'{Z0,Z0},'{P1,Z0},'{P2,Z0}}, '{'{Z0,M1},'{Z0,Z0},'{Z0,P1},'{Z0,P2}},
        '{'{M1,Z0},'{Z0,Z0},'{P1,Z0},'{P2,Z0}}, '{'{Z0,M1},'{Z0,Z0},'{Z0,P1},'{Z0,P2}}},
      '{'{'{Z0,Z0},'{P1,Z0},'{Z0,P1},'{P1,P1}}, '{'{Z0,Z0},'{P1,Z0},'{Z0,P1},'{P1,P1}},
        '{'{Z0,Z0},'{P1,Z0},'{Z0,P1},'{P1,P1}}, '{'{Z0,Z0},'{P1,Z0},'{Z0,P1},'{P1,P1}}},
      '{'{'{M1,Z0},'{Z0,Z0},'{P1,Z0},'{Z0,M1}}, '{'{Z0,M1},'{Z0,Z0},'{Z0,P1},'{P1,Z0}},
        '{'{P1,Z0},'{Z0,Z0},'{M1,Z0},'{Z0,P1}}, '{'{Z0,P1},'{Z0,Z0},'{Z0,M1},'{M1,Z0}}},
      '{'{'{Z0,Z0},'{P1,Z0},'{M1,P1},'{Z0,P1}}, '{'{Z0,Z0},'{Z0,P1},'{M1,M1},'{M1,Z0}},
        '{'{Z0,Z0},'{M1,Z0},'{P1,M1},'{Z0,M1}}, '{'{Z0,Z0},'{Z0,M1},'{P1,P1},'{P1,Z0}}},
      '{'{'{M1,Z0},'{Z0,Z0},'{Z0,P1},'{P1,P1}}, '{'{Z0,M1},'{Z0,Z0},'{M1,Z0},'{M1,P1}},
        '{'{P1,Z0},'{Z0,Z0},'{Z0,M1},'{M1,M1}}, '{'{Z0,P1},'{Z0,Z0},'{P1,Z0},'{P1,M1}}},
      '{'{'{M1,M1},'{M1,Z0},'{Z0,Z0},'{P1,Z0}}, '{'{P1,M1},'{Z0,M1},'{Z0,Z0},'{Z0,P1}},
        '{'{P1,P1},'{P1,Z0},'{Z0,Z0},'{M1,Z0}}, '{'{M1,P1},'{Z0,P1},'{Z0,Z0},'{Z0,M1}}},
      '{'{'{P1,M1},'{M1,Z0},'{Z0,Z0},'{P1,Z0}}, '{'{P1,P1},'{Z0,M1},'{Z0,Z0},'{Z0,P1}},
        '{'{M1,P1},'{P1,Z0},'{Z0,Z0},'{M1,Z0}}, '{'{M1,M1},'{Z0,P1},'{Z0,Z0},'{Z0,M1}}}
   };
`else
   localparam int N_ROT = 1;
   localparam off_pair_t SHAPE_TBL [0:6][0:N_ROT-1][0:3] = '{
      '{'{'{M1,Z0},'{Z0,Z0},'{P1,Z0},'{P2,Z0}}},
      '{'{'{Z0,Z0},'{P1,Z0},'{Z0,P1},'{P1,P1}}},
      '{'{'{M1,Z0},'{Z0,Z0},'{P1,Z0},'{Z0,M1}}},
      '{'{'{Z0,Z0},'{P1,Z0},'{M1,P1},'{Z0,P1}}},
      '{'{'{M1,Z0},'{Z0,Z0},'{Z0,P1},'{P1,P1}}},
      '{'{'{M1,M1},'{M1,Z0},'{Z0,Z0},'{P1,Z0}}},
      '{'{'{P1,M1},'{M1,Z0},'{Z0,Z0},'{P1,Z0}}}
   };
`endif
   function automatic logic [2:0] color_of(input logic [2:0] t);
      return t + 3'd1;
   endfunction
   // Restoring division by 7: subtract 224, 112, 56, 28, 14, 7 where they fit.
   function automatic logic [2:0] mod7(input logic [7:0] x);
      logic [7:0] r;
      r = x;
      for (int k = 5; k >= 0; k--) if (r >= (8'd7 << k)) r = r - (8'd7 << k);
      return 3'(r);
   endfunction
endpackage

// File: rtl/piece_shape_rom.sv
// piece_shape_rom: combinational (type, rotation, anchor) to four cell coordinates.
// PIECE_MOVER_ROTATE_EN enables rotation indexing; otherwise rotation 0 is always used.
module piece_shape_rom
   import tetris_pkg::*;
(
   input  logic [2:0]      type_i,
   input  logic [1:0]      rot_i,
   input  logic [4:0]      v_i,
   input  logic [4:0]      h_i,
   output logic [3:0][4:0] v_o,
   output logic [3:0][4:0] h_o
);
   off_pair_t off [0:3];
`ifdef PIECE_MOVER_ROTATE_EN
   assign off = SHAPE_TBL[type_i][rot_i];
`else
   logic unused_rot;
   assign off = SHAPE_TBL[type_i][0];
   assign unused_rot = ^rot_i;
`endif
   for (genvar c = 0; c < 4; c++) begin : g_cell
      assign v_o[c] = 5'({1'b0, v_i} + {{3{off[c].dv[2]}}, off[c].dv});
      assign h_o[c] = 5'({1'b0, h_i} + {{3{off[c].dh[2]}}, off[c].dh});
   end
endmodule

// File: rtl/piece_mover.sv
// piece_mover: active-piece controller requesting moves from block memory and spawning pieces.
// PIECE_MOVER_ROTATE_EN enables btn_rotate; otherwise rotation stays 0.
module piece_mover
   import tetris_pkg::*;
#(
   parameter logic [4:0] SPAWN_V   = 5'd5,
   parameter logic [4:0] SPAWN_H   = 5'd1,
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_rotate,
   input  logic       gravity_tick,
   input  logic       movement_commit,
   input  logic       movement_declined,
   input  logic       movement_steal,
   output logic       movement_request,
   output logic       movement_intent,
   output logic [4:0] P1blk_v,
   output logic [4:0] P1blk_h,
   output logic [4:0] P2blk_v,
   output logic [4:0] P2blk_h,
   output logic [4:0] P3blk_v,
   output logic [4:0] P3blk_h,
   output logic [4:0] P4blk_v,
   output logic [4:0] P4blk_h,
   output logic [2:0] volatile_blk_color,
   output logic       piece_locked,
   output logic       game_over
);
   state_t          state_q;
   logic [7:0]      lfsr_q, lfsr_d;
   logic [2:0]      type_q, ptype_q;
   logic [1:0]      rot_q, prot_q;
   logic [4:0]      v_q, h_q, pv_q, ph_q;
   logic [3:0]      pend_q, pend_d, pulse, ev, take;
   logic            spawn_q, next_spawn_q, rel_q, req_q, intent_q, locked_q, over_q;
   logic            show;
   logic [3:0][4:0] cur_v, cur_h, prp_v, prp_h, out_v, out_h;
   // Event bits: 0 gravity, 1 left, 2 right, 3 rotate; lowest set bit wins.
`ifdef PIECE_MOVER_ROTATE_EN
   assign pulse = {btn_rotate, btn_right, btn_left, gravity_tick};
`else
   logic unused_rot;
   assign unused_rot = btn_rotate;
   assign pulse = {1'b0, btn_right, btn_left, gravity_tick};
`endif
   assign ev     = pend_q | pulse;
   assign take   = ev & (~ev + 4'd1);
   assign pend_d = (state_q == OVER) ? 4'd0 : ev & ~((state_q == IDLE) ? take : 4'd0);
   assign lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= SPAWN;
         lfsr_q       <= LFSR_SEED;
         type_q       <= mod7(LFSR_SEED);
         rot_q        <= 2'd0;
         v_q          <= SPAWN_V;
         h_q          <= SPAWN_H;
         ptype_q      <= mod7(LFSR_SEED);
         prot_q       <= 2'd0;
         pv_q         <= SPAWN_V;
         ph_q         <= SPAWN_H;
         pend_q       <= 4'd0;
         spawn_q      <= 1'b0;
         next_spawn_q <= 1'b0;
         rel_q        <= 1'b0;
         req_q        <= 1'b0;
         intent_q     <= 1'b0;
         locked_q     <= 1'b0;
         over_q       <= 1'b0;
      end else begin
         locked_q <= 1'b0;
         pend_q   <= pend_d;
         case (state_q)
            SPAWN: begin
               ptype_q  <= mod7(lfsr_q);
               prot_q   <= 2'd0;
               pv_q     <= SPAWN_V;
               ph_q     <= SPAWN_H;
               intent_q <= 1'b1;
               req_q    <= 1'b1;
               spawn_q  <= 1'b1;
               state_q  <= REQ;
            end
            IDLE: if (|ev) begin
               ptype_q  <= type_q;
               prot_q   <= rot_q + {1'b0, take[3]};
               pv_q     <= take[1] ? v_q - 5'd1 : take[2] ? v_q + 5'd1 : v_q;
               ph_q     <= take[0] ? h_q + 5'd1 : h_q;
               intent_q <= ~take[0];
               req_q    <= 1'b1;
               state_q  <= REQ;
            end
            REQ: if (movement_steal | movement_declined | movement_commit) begin
               req_q   <= 1'b0;
               spawn_q <= 1'b0;
               rel_q   <= 1'b0;
               if (movement_steal) begin
                  locked_q     <= 1'b1;
                  lfsr_q       <= lfsr_d;
                  next_spawn_q <= 1'b1;
                  state_q      <= RELEASE;
               end else if (movement_declined) begin
                  over_q  <= spawn_q;
                  state_q <= spawn_q ? OVER : RELEASE;
               end else begin
                  type_q  <= ptype_q;
                  rot_q   <= prot_q;
                  v_q     <= pv_q;
                  h_q     <= ph_q;
                  state_q <= RELEASE;
               end
            end
            RELEASE: begin
               rel_q <= 1'b1;
               if (rel_q) begin
                  state_q      <= next_spawn_q ? SPAWN : IDLE;
                  next_spawn_q <= 1'b0;
               end
            end
            OVER: over_q <= 1'b1;
            default: state_q <= SPAWN;
         endcase
      end
   end
   piece_shape_rom u_cur (.type_i(type_q), .rot_i(rot_q), .v_i(v_q), .h_i(h_q), .v_o(cur_v), .h_o(cur_h));
   piece_shape_rom u_prp (.type_i(ptype_q), .rot_i(prot_q), .v_i(pv_q), .h_i(ph_q), .v_o(prp_v), .h_o(prp_h));
   assign show               = state_q == REQ;
   assign out_v              = show ? prp_v : cur_v;
   assign out_h              = show ? prp_h : cur_h;
   assign volatile_blk_color = color_of(show ? ptype_q : type_q);
   assign movement_request   = req_q;
   assign movement_intent    = intent_q;
   assign piece_locked       = locked_q;
   assign game_over          = over_q;
   assign P1blk_v = out_v[0];
   assign P1blk_h = out_h[0];
   assign P2blk_v = out_v[1];
   assign P2blk_h = out_h[1];
   assign P3blk_v = out_v[2];
   assign P3blk_h = out_h[2];
   assign P4blk_v = out_v[3];
   assign P4blk_h = out_h[3];
endmodule

// File: tb/tb_piece_mover.sv
// tb_piece_mover: directed self-checking bench for piece_mover with hand-computed cell positions.
module tb_piece_mover;
   logic       clk = 1'b0, reset = 1'b1;
   logic       btn_left = 1'b0, btn_right = 1'b0, btn_rotate = 1'b0, gravity_tick = 1'b0;
   logic       movement_commit = 1'b0, movement_declined = 1'b0, movement_steal = 1'b0;
   logic       movement_request, movement_intent, piece_locked, game_over;
   logic [4:0] P1blk_v, P1blk_h, P2blk_v, P2blk_h, P3blk_v, P3blk_h, P4blk_v, P4blk_h;
   logic [2:0] volatile_blk_color;
   int         n_chk = 0, n_pass = 0;
   always #5 clk = ~clk;
   piece_mover dut (
      .clk(clk), .reset(reset), .btn_left(btn_left), .btn_right(btn_right),
      .btn_rotate(btn_rotate), .gravity_tick(gravity_tick),
      .movement_commit(movement_commit), .movement_declined(movement_declined),
      .movement_steal(movement_steal), .movement_request(movement_request),
      .movement_intent(movement_intent),
      .P1blk_v(P1blk_v), .P1blk_h(P1blk_h), .P2blk_v(P2blk_v), .P2blk_h(P2blk_h),
      .P3blk_v(P3blk_v), .P3blk_h(P3blk_h), .P4blk_v(P4blk_v), .P4blk_h(P4blk_h),
      .volatile_blk_color(volatile_blk_color), .piece_locked(piece_locked), .game_over(game_over)
   );
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   function automatic logic [19:0] pk(input int a, input int b, input int c, input int d);
      return {5'(a), 5'(b), 5'(c), 5'(d)};
   endfunction
   task automatic cells(input string tag, input logic [19:0] ev, input logic [19:0] eh);
      chk({tag, "_v"}, 32'({P1blk_v, P2blk_v, P3blk_v, P4blk_v}), 32'(ev));
      chk({tag, "_h"}, 32'({P1blk_h, P2blk_h, P3blk_h, P4blk_h}), 32'(eh));
   endtask
   task automatic reqs(input string tag, input logic r, input logic i);
      chk({tag, "_req"}, 32'(movement_request), 32'(r));
      chk({tag, "_intent"}, 32'(movement_intent), 32'(i));
   endtask
   // kind: 0 commit, 1 declined, 2 steal
   task automatic strobe(input int kind);
      movement_commit   = kind == 0;
      movement_declined = kind == 1;
      movement_steal    = kind == 2;
      step();
      movement_commit   = 1'b0;
      movement_declined = 1'b0;
      movement_steal    = 1'b0;
   endtask
   initial begin
      step(2);
      reqs("rst", 1'b0, 1'b0);
      chk("rst_locked", 32'(piece_locked), 32'd0);
      chk("rst_over", 32'(game_over), 32'd0);
      chk("rst_color", 32'(volatile_blk_color), 32'd5);
      cells("rst", pk(4, 5, 5, 6), pk(1, 1, 2, 2));
      reset = 1'b0;
      step();
      reqs("spawn", 1'b1, 1'b1);
      cells("spawn", pk(4, 5, 5, 6), pk(1, 1, 2, 2));
      strobe(0);
      chk("spawn_commit_req", 32'(movement_request), 32'd0);
      cells("spawn_commit", pk(4, 5, 5, 6), pk(1, 1, 2, 2));
      step(2);
      btn_left = 1'b1;
      step();
      btn_left = 1'b0;
      reqs("left", 1'b1, 1'b1);
      cells("left", pk(3, 4, 4, 5), pk(1, 1, 2, 2));
      step(3);
      chk("left_hold_req", 32'(movement_request), 32'd1);
      cells("left_hold", pk(3, 4, 4, 5), pk(1, 1, 2, 2));
      strobe(0);
      chk("left_rel1_req", 32'(movement_request), 32'd0);
      cells("left_commit", pk(3, 4, 4, 5), pk(1, 1, 2, 2));
      step();
      chk("left_rel2_req", 32'(movement_request), 32'd0);
      step();
      chk("left_idle_req", 32'(movement_request), 32'd0);
      btn_right = 1'b1;
      step();
      btn_right = 1'b0;
      reqs("right", 1'b1, 1'b1);
      cells("right", pk(4, 5, 5, 6), pk(1, 1, 2, 2));
      strobe(1);
      chk("right_decl_req", 32'(movement_request), 32'd0);
      chk("right_decl_over", 32'(game_over), 32'd0);
      cells("right_decl", pk(3, 4, 4, 5), pk(1, 1, 2, 2));
      step(2);
      gravity_tick = 1'b1;
      btn_left     = 1'b1;
      step();
      gravity_tick = 1'b0;
      btn_left     = 1'b0;
      reqs("grav", 1'b1, 1'b0);
      cells("grav", pk(3, 4, 4, 5), pk(2, 2, 3, 3));
      strobe(0);
      step(2);
      chk("grav_idle_req", 32'(movement_request), 32'd0);
      step();
      reqs("pend_left", 1'b1, 1'b1);
      cells("pend_left", pk(2, 3, 3, 4), pk(2, 2, 3, 3));
      strobe(0);
      step(2);
      gravity_tick = 1'b1;
      step();
      gravity_tick = 1'b0;
      cells("land", pk(2, 3, 3, 4), pk(3, 3, 4, 4));
      strobe(2);
      chk("steal_locked", 32'(piece_locked), 32'd1);
      chk("steal_req", 32'(movement_request), 32'd0);
      cells("steal", pk(2, 3, 3, 4), pk(2, 2, 3, 3));
      step();
      chk("steal_locked_end", 32'(piece_locked), 32'd0);
      step(2);
      reqs("spawn2", 1'b1, 1'b1);
      chk("spawn2_color", 32'(volatile_blk_color), 32'd5);
      cells("spawn2", pk(4, 5, 5, 6), pk(1, 1, 2, 2));
      strobe(2);
      chk("steal2_locked", 32'(piece_locked), 32'd1);
      step(3);
      reqs("spawn3", 1'b1, 1'b1);
      chk("spawn3_color", 32'(volatile_blk_color), 32'd3);
      cells("spawn3", pk(4, 5, 6, 5), pk(1, 1, 1, 0));
      strobe(0);
      step(2);
      movement_steal = 1'b1;
      step();
      movement_steal = 1'b0;
      chk("idle_steal_locked", 32'(piece_locked), 32'd0);
      chk("idle_steal_req", 32'(movement_request), 32'd0);
      cells("idle_steal", pk(4, 5, 6, 5), pk(1, 1, 1, 0));
      btn_rotate = 1'b1;
      step();
      btn_rotate = 1'b0;
`ifdef PIECE_MOVER_ROTATE_EN
      reqs("rot", 1'b1, 1'b1);
      cells("rot", pk(5, 5, 5, 6), pk(0, 1, 2, 1));
      strobe(0);
      step(2);
`else
      chk("rot_req", 32'(movement_request), 32'd0);
      step(2);
      chk("rot_req_late", 32'(movement_request), 32'd0);
`endif
      gravity_tick = 1'b1;
      step();
      gravity_tick = 1'b0;
      strobe(2);
      step(3);
      reqs("spawn4", 1'b1, 1'b1);
      chk("spawn4_color", 32'(volatile_blk_color), 32'd1);
      cells("spawn4", pk(4, 5, 6, 7), pk(1, 1, 1, 1));
      strobe(1);
      chk("over", 32'(game_over), 32'd1);
      chk("over_req", 32'(movement_request), 32'd0);
      gravity_tick = 1'b1;
      btn_left     = 1'b1;
      step();
      gravity_tick = 1'b0;
      btn_left     = 1'b0;
      step(4);
      chk("over_sticky", 32'(game_over), 32'd1);
      chk("over_no_req", 32'(movement_request), 32'd0);
      reset = 1'b1;
      step();
      chk("rst2_over", 32'(game_over), 32'd0);
      chk("rst2_req", 32'(movement_request), 32'd0);
      chk("rst2_color", 32'(volatile_blk_color), 32'd5);
      reset = 1'b0;
      step();
      chk("rst2_spawn_req", 32'(movement_request), 32'd1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
